// File: rtl/car_pkg.sv
// Shared definitions for the car playfield: initial car table, per-car speeds,
// orientation codes, car extents and the position-manager FSM states.
package car_pkg;

    localparam int CAR_COUNT = 8;

    localparam logic [1:0] ORIENT_H = 2'd0;   // 60x30, moves +X
    localparam logic [1:0] ORIENT_V = 2'd1;   // 30x60, moves +Y

    localparam int CAR_LONG  = 60;
    localparam int CAR_SHORT = 30;

    // Car 0 is the player; cars 1-7 are traffic.
    localparam logic [9:0] INIT_X [CAR_COUNT] = '{
        10'd0, 10'd630, 10'd100, 10'd300, 10'd500, 10'd50, 10'd200, 10'd400
    };
    localparam logic [9:0] INIT_Y [CAR_COUNT] = '{
        10'd100, 10'd40, 10'd200, 10'd470, 10'd300, 10'd350, 10'd150, 10'd60
    };
    localparam logic [1:0] INIT_ORIENT [CAR_COUNT] = '{
        ORIENT_H, ORIENT_H, ORIENT_V, ORIENT_V, ORIENT_H, ORIENT_V, ORIENT_H, ORIENT_V
    };
    // Speed of car 0 is unused; the player moves by PLAYER_STEP instead.
    localparam logic [2:0] CAR_SPEED [CAR_COUNT] = '{
        3'd0, 3'd4, 3'd2, 3'd3, 3'd1, 3'd4, 3'd3, 3'd1
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_FROZEN = 2'd2
    } carFsm_t;

    // Horizontal extent of a car in the given orientation.
    function automatic logic [10:0] carWidth(input logic [1:0] orient);
        return (orient == ORIENT_V) ? 11'(CAR_SHORT) : 11'(CAR_LONG);
    endfunction

    // Vertical extent of a car in the given orientation.
    function automatic logic [10:0] carHeight(input logic [1:0] orient);
        return (orient == ORIENT_V) ? 11'(CAR_LONG) : 11'(CAR_SHORT);
    endfunction

endpackage

// File: rtl/car_step.sv
// Combinational next-position for one car. Traffic cars advance by their speed
// along their orientation and wrap at the screen edge; the player car moves by
// one button (up > down > left > right) and saturates inside the screen.
module car_step
    import car_pkg::*;
#(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int PLAYER_STEP = 4
) (
    input  logic       isPlayer,
    input  logic [9:0] curX,
    input  logic [9:0] curY,
    input  logic [1:0] curOrient,
    input  logic [2:0] speed,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnLeft,
    input  logic       btnRight,
    output logic [9:0] nextX,
    output logic [9:0] nextY,
    output logic [1:0] nextOrient
);

    localparam logic [10:0] SCREEN_W11 = 11'(SCREEN_W);
    localparam logic [10:0] SCREEN_H11 = 11'(SCREEN_H);
    localparam logic [10:0] STEP11     = 11'(PLAYER_STEP);

    logic [10:0] trafSum;
    logic [9:0]  trafX;
    logic [9:0]  trafY;

    logic [10:0] plX;
    logic [10:0] plY;
    logic [10:0] plMaxX;
    logic [10:0] plMaxY;
    logic [1:0]  plOrient;
    logic        plMoved;

    // Traffic: advance along the orientation axis, wrapping by one screen extent.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        trafSum = '0;
        trafX   = curX;
        trafY   = curY;
        if (curOrient == ORIENT_V) begin
            trafSum = {1'b0, curY} + {8'd0, speed};
            if (trafSum >= SCREEN_H11) trafSum = trafSum - SCREEN_H11;
            trafY = trafSum[9:0];
        end else begin
            trafSum = {1'b0, curX} + {8'd0, speed};
            if (trafSum >= SCREEN_W11) trafSum = trafSum - SCREEN_W11;
            trafX = trafSum[9:0];
        end
    end

    // Player: single prioritised button move, then clamp both axes using the
    // extents of the new orientation so a turn near an edge stays on screen.
    always_comb begin
        plX      = {1'b0, curX};
        plY      = {1'b0, curY};
        plOrient = curOrient;
        plMoved  = btnUp | btnDown | btnLeft | btnRight;
        if (btnUp) begin
            plOrient = ORIENT_V;
            plY      = (plY >= STEP11) ? plY - STEP11 : 11'd0;
        end else if (btnDown) begin
            plOrient = ORIENT_V;
            plY      = plY + STEP11;
        end else if (btnLeft) begin
            plOrient = ORIENT_H;
            plX      = (plX >= STEP11) ? plX - STEP11 : 11'd0;
        end else if (btnRight) begin
            plOrient = ORIENT_H;
            plX      = plX + STEP11;
        end
        plMaxX = SCREEN_W11 - carWidth(plOrient);
        plMaxY = SCREEN_H11 - carHeight(plOrient);
        if (plMoved) begin
            if (plX > plMaxX) plX = plMaxX;
            if (plY > plMaxY) plY = plMaxY;
        end
    end

    assign nextX      = isPlayer ? plX[9:0] : trafX;
    assign nextY      = isPlayer ? plY[9:0] : trafY;
    assign nextOrient = isPlayer ? plOrient : curOrient;

endmodule

// File: rtl/car_position_manager.sv
// Holds position/orientation of all cars, sweeps one car update per cycle on
// each game tick, and streams one car per cycle round-robin to collision
// detection. A collision freezes the game until restart or reset.
module car_position_manager
    import car_pkg::*;
#(
    parameter int NUM_CARS    = 8,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int PLAYER_STEP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       collision,
    input  logic       restart,
    output logic [3:0] carIndex,
    output logic [9:0] carX,
    output logic [9:0] carY,
    output logic [1:0] carOrient,
    output logic       frozen,
    output logic       busy
);

    localparam int                IDXW     = $clog2(NUM_CARS);
    localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(NUM_CARS - 1);

    logic [9:0] posX   [NUM_CARS];
    logic [9:0] posY   [NUM_CARS];
    logic [1:0] orient [NUM_CARS];

    carFsm_t         state;
    logic [IDXW-1:0] upd_idx;
    logic [IDXW-1:0] scan_idx;

    logic [9:0] stepX;
    logic [9:0] stepY;
    logic [1:0] stepOrient;

    // Single shared next-state calculator, pointed at the car being swept.
    car_step #(
        .SCREEN_W   (SCREEN_W),
        .SCREEN_H   (SCREEN_H),
        .PLAYER_STEP(PLAYER_STEP)
    ) u_step (
        .isPlayer  (upd_idx == '0),
        .curX      (posX[upd_idx]),
        .curY      (posY[upd_idx]),
        .curOrient (orient[upd_idx]),
        .speed     (CAR_SPEED[upd_idx]),
        .btnUp     (btn_up),
        .btnDown   (btn_down),
        .btnLeft   (btn_left),
        .btnRight  (btn_right),
        .nextX     (stepX),
        .nextY     (stepY),
        .nextOrient(stepOrient)
    );

    // Sweep FSM plus the car state it writes; restart beats collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            upd_idx <= '0;
            frozen  <= 1'b0;
            busy    <= 1'b0;
            // NOTE: the car table is a handful of registers that must come up at
            // known start positions, so it is reset here rather than left to RAM.
            for (int i = 0; i < NUM_CARS; i++) begin
                posX[i]   <= INIT_X[i];
                posY[i]   <= INIT_Y[i];
                orient[i] <= INIT_ORIENT[i];
            end
        end else if (restart) begin
            state   <= ST_IDLE;
            upd_idx <= '0;
            frozen  <= 1'b0;
            busy    <= 1'b0;
            for (int i = 0; i < NUM_CARS; i++) begin
                posX[i]   <= INIT_X[i];
                posY[i]   <= INIT_Y[i];
                orient[i] <= INIT_ORIENT[i];
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            case (state)
                ST_IDLE: begin
                    if (collision) begin
                        state  <= ST_FROZEN;
                        frozen <= 1'b1;
                    end else if (move_tick) begin
                        state   <= ST_UPDATE;
                        upd_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    posX[upd_idx]   <= stepX;
                    posY[upd_idx]   <= stepY;
                    orient[upd_idx] <= stepOrient;
                    if (collision) begin
                        state  <= ST_FROZEN;
                        frozen <= 1'b1;
                        busy   <= 1'b0;
                    end else if (upd_idx == LAST_IDX) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        upd_idx <= upd_idx + 1'b1;
                    end
                end
                ST_FROZEN: begin
                    frozen <= 1'b1;
                    busy   <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Free-running round-robin stream of car state into collision detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_idx  <= IDXW'(1);
            carIndex  <= 4'd0;
            carX      <= INIT_X[0];
            carY      <= INIT_Y[0];
            carOrient <= INIT_ORIENT[0];
        end else begin
            carIndex  <= 4'(scan_idx);
            carX      <= posX[scan_idx];
            carY      <= posY[scan_idx];
            carOrient <= orient[scan_idx];
            scan_idx  <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_car_position_manager.sv
// Self-checking bench for car_position_manager: table-driven reset/player
// vectors, hand-written sweep/collision/reset sequences and a randomized run
// against a behavioural model of the car rules.
module tb_car_position_manager;

    localparam int SW   = 640;
    localparam int SH   = 480;
    localparam int STEP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       move_tick;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       collision;
    logic       restart;
    logic [3:0] carIndex;
    logic [9:0] carX, carY;
    logic [1:0] carOrient;
    logic       frozen, busy;

    car_position_manager #(
        .NUM_CARS(8), .SCREEN_W(SW), .SCREEN_H(SH), .PLAYER_STEP(STEP)
    ) dut (
        .clk(clk), .rst(rst), .move_tick(move_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .collision(collision), .restart(restart),
        .carIndex(carIndex), .carX(carX), .carY(carY), .carOrient(carOrient),
        .frozen(frozen), .busy(busy)
    );

    always #5 clk = ~clk;

    // Independent copy of the start table and speeds.
    localparam int INIT_XT [8] = '{0, 630, 100, 300, 500, 50, 200, 400};
    localparam int INIT_YT [8] = '{100, 40, 200, 470, 300, 350, 150, 60};
    localparam int INIT_OT [8] = '{0, 0, 1, 1, 0, 1, 0, 1};
    localparam int SPEED   [8] = '{0, 4, 2, 3, 1, 4, 3, 1};

    int nCompared   = 0;
    int nMismatched = 0;
    int mX [8];
    int mY [8];
    int mO [8];

    typedef struct {
        int idx; int x; int y; int o;
    } slotVec_t;

    typedef struct {
        logic [3:0] btns;  // {up, down, left, right}
        int x; int y; int o;
    } playerVec_t;

    task automatic check(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int clampInt(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 8; i++) begin
            mX[i] = INIT_XT[i]; mY[i] = INIT_YT[i]; mO[i] = INIT_OT[i];
        end
    endtask

    // Apply one tick's movement to cars 0..lastCar.
    task automatic modelTick(input logic [3:0] b, input int lastCar);
        int w, h;
        for (int i = 1; i <= lastCar; i++) begin
            if (mO[i] == 0) mX[i] = (mX[i] + SPEED[i]) % SW;
            else            mY[i] = (mY[i] + SPEED[i]) % SH;
        end
        if (b != 4'b0000) begin
            if      (b[3]) begin mO[0] = 1; mY[0] = mY[0] - STEP; end
            else if (b[2]) begin mO[0] = 1; mY[0] = mY[0] + STEP; end
            else if (b[1]) begin mO[0] = 0; mX[0] = mX[0] - STEP; end
            else           begin mO[0] = 0; mX[0] = mX[0] + STEP; end
            w = (mO[0] == 1) ? 30 : 60;
            h = (mO[0] == 1) ? 60 : 30;
            mX[0] = clampInt(mX[0], 0, SW - w);
            mY[0] = clampInt(mY[0], 0, SH - h);
        end
    endtask

    // Watch one full round of the stream and compare every slot to the model.
    task automatic scanAll(input string name);
        int prev, idx;
        prev = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            idx = int'(carIndex);
            if (prev >= 0) check({name, "_seq"}, idx, (prev + 1) % 8);
            check({name, "_x"}, int'(carX),      mX[idx % 8]);
            check({name, "_y"}, int'(carY),      mY[idx % 8]);
            check({name, "_o"}, int'(carOrient), mO[idx % 8]);
            prev = idx;
        end
    endtask

    task automatic readCar(input int i, output int x, output int y, output int o);
        bit found;
        found = 0; x = -1; y = -1; o = -1;
        for (int k = 0; k < 16 && !found; k++) begin
            @(negedge clk);
            if (int'(carIndex) == i) begin
                found = 1; x = int'(carX); y = int'(carY); o = int'(carOrient);
            end
        end
        if (!found) check("readCar_timeout", 0, 1);
    endtask

    task automatic setBtns(input logic [3:0] b);
        {btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    // One tick with buttons held for the whole sweep, then update the model.
    task automatic doTick(input logic [3:0] b);
        int n;
        @(negedge clk);
        setBtns(b);
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("sweep_timeout", 0, 1);
        setBtns(4'b0000);
        modelTick(b, 7);
    endtask

    slotVec_t   resetVecs  [9];
    playerVec_t playerVecs [6];
    int         wrapExp    [3];

    initial begin
        int x, y, o;
        logic [3:0] b;
        int fav [4];

        resetVecs[0] = '{0, 0, 100, 0};
        resetVecs[1] = '{1, 630, 40, 0};
        resetVecs[2] = '{2, 100, 200, 1};
        resetVecs[3] = '{3, 300, 470, 1};
        resetVecs[4] = '{4, 500, 300, 0};
        resetVecs[5] = '{5, 50, 350, 1};
        resetVecs[6] = '{6, 200, 150, 0};
        resetVecs[7] = '{7, 400, 60, 1};
        resetVecs[8] = '{0, 0, 100, 0};

        playerVecs[0] = '{4'b0010, 0, 100, 0};   // left at x=0: saturates
        playerVecs[1] = '{4'b1001, 0, 96, 1};    // up+right: up wins
        playerVecs[2] = '{4'b0100, 0, 100, 1};   // down
        playerVecs[3] = '{4'b0001, 4, 100, 0};   // right, turn horizontal
        playerVecs[4] = '{4'b0000, 4, 100, 0};   // nothing pressed
        playerVecs[5] = '{4'b1000, 4, 96, 1};    // up

        wrapExp = '{634, 638, 2};
        fav     = '{0, 2, 1, 3};                 // right, down, left, up

        rst = 1'b1; move_tick = 1'b0; collision = 1'b0; restart = 1'b0;
        setBtns(4'b0000);
        modelReset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset stream: slot 0 presented now, then 1..7, 0 on following cycles.
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            check("rst_idx", int'(carIndex),  resetVecs[k].idx);
            check("rst_x",   int'(carX),      resetVecs[k].x);
            check("rst_y",   int'(carY),      resetVecs[k].y);
            check("rst_o",   int'(carOrient), resetVecs[k].o);
            check("rst_frozen", int'(frozen), 0);
            check("rst_busy",   int'(busy),   0);
        end

        // Traffic car 1 wrapping at the right edge.
        for (int t = 0; t < 3; t++) begin
            doTick(4'b0000);
            readCar(1, x, y, o);
            check("wrap_car1_x", x, wrapExp[t]);
        end
        scanAll("wrap");

        // Player moves from table.
        for (int k = 0; k < 6; k++) begin
            doTick(playerVecs[k].btns);
            readCar(0, x, y, o);
            check("player_x", x, playerVecs[k].x);
            check("player_y", y, playerVecs[k].y);
            check("player_o", o, playerVecs[k].o);
        end
        scanAll("player");

        // Second tick 3 cycles into a sweep is dropped; busy spans 8 cycles.
        @(negedge clk);
        move_tick = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) move_tick = 1'b0;
            if (k == 3) move_tick = 1'b1;
            if (k == 4) move_tick = 1'b0;
            check("dual_busy", int'(busy), (k <= 8) ? 1 : 0);
        end
        modelTick(4'b0000, 7);
        scanAll("dual");

        // Collision sampled on the 4th sweep edge: cars 0-3 advance, 4-7 keep.
        @(negedge clk);
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("coll_frozen_before", int'(frozen), 0);
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        check("coll_frozen_after", int'(frozen), 1);
        check("coll_busy_after",   int'(busy),   0);
        modelTick(4'b0000, 3);
        scanAll("coll");

        // Ticks while frozen are ignored.
        @(negedge clk);
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        check("frozen_busy", int'(busy), 0);
        repeat (10) @(negedge clk);
        check("frozen_hold", int'(frozen), 1);
        scanAll("frozen");

        // Restart reloads the table and clears the freeze.
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_frozen", int'(frozen), 0);
        modelReset();
        scanAll("restart");

        // Restart and collision together: restart wins.
        @(negedge clk);
        restart = 1'b1; collision = 1'b1;
        @(negedge clk);
        restart = 1'b0; collision = 1'b0;
        check("restart_wins", int'(frozen), 0);

        // Randomized play: phases biased toward one button to reach the edges.
        for (int t = 0; t < 800; t++) begin
            if ($urandom_range(0, 9) < 9) b = 4'(1 << fav[t / 200]);
            else                          b = 4'($urandom_range(0, 15));
            doTick(b);
            if (t % 4 == 3) scanAll("rand");
        end

        // Asynchronous reset in the middle of a sweep.
        @(negedge clk);
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        @(negedge clk);
        check("busy_before_rst", int'(busy), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_idx",    int'(carIndex),  0);
        check("async_x",      int'(carX),      0);
        check("async_y",      int'(carY),      100);
        check("async_o",      int'(carOrient), 0);
        check("async_frozen", int'(frozen),    0);
        check("async_busy",   int'(busy),      0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        scanAll("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/car_position_manager.md
# car_position_manager

Holds position and orientation of all 8 cars (car 0 player-controlled, cars 1-7 autonomous traffic). Advances every car once per game tick and streams one car per clock, round-robin, into `collision_detection` via `carIndex/carX/carY/carOrient`. Sits directly upstream of `collision_detection` and takes its `collision` output back as a freeze request.

## Interface
Parameters:
- `NUM_CARS`, 8, number of cars; index width fixed at 4 bits
- `SCREEN_W`, 640, playfield width in pixels
- `SCREEN_H`, 480, playfield height in pixels
- `PLAYER_STEP`, 4, car 0 pixels per tick

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `move_tick`  in  1  one-cycle game-tick pulse
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  player controls, already debounced, level
- `collision`  in  1  from `collision_detection`
- `restart`  in  1  one-cycle pulse; reloads initial state, clears freeze
- `carIndex`  out  4  index of car presented this cycle
- `carX`, `carY`  out  10 each  top-left pixel of presented car
- `carOrient`  out  2  0 = horizontal (60x30, moves +X), 1 = vertical (30x60, moves +Y); 2/3 never driven
- `frozen`  out  1  game halted after collision
- `busy`  out  1  update sweep in progress

## Operation
- State per car: x[9:0], y[9:0], orient[1:0]. Reset/restart load `INIT_X/INIT_Y/INIT_ORIENT[i]`.
- FSM: IDLE, UPDATE, FROZEN.
  - IDLE: `move_tick` and not frozen -> UPDATE with `upd_idx`=0.
  - UPDATE: one car per cycle, `upd_idx` 0..7; after index 7 -> IDLE. `busy`=1 only here.
  - FROZEN: entered from any state the cycle after `collision`=1 is sampled; ticks ignored; exit only by `rst` or `restart` (-> IDLE, state reloaded).
- `move_tick` during UPDATE or FROZEN is dropped, not queued.
- Traffic car i (1-7): add `CAR_SPEED[i]` (1-4) along its orientation; if sum >= SCREEN_W (X) or SCREEN_H (Y), subtract that bound (wrap). Compute in 11 bits, truncate to 10.
- Car 0: one button per tick, priority up > down > left > right; none pressed -> unchanged. Up/down set orient 1, left/right set orient 0. Move by `PLAYER_STEP`, saturating: x in [0, SCREEN_W - width], y in [0, SCREEN_H - height], with width/height from the new orientation. Orientation change that leaves the car out of bounds clamps it into bounds the same cycle.
- Stream: free-running `scan_idx` 0..7, increments every cycle in all states, wraps 7 -> 0. Outputs are registered from `scan_idx`'s car state.
- `restart` and `collision` asserted together: restart wins.

## Timing
- Reset values: `carIndex`=0, `carX/carY/carOrient`=INIT of car 0, `frozen`=0, `busy`=0, FSM=IDLE, `scan_idx`=1 (next to present).
- Tick at cycle T -> car k updated at edge T+1+k; sweep ends, `busy` low, at T+9.
- Car update visible on the stream within 9 cycles (≤8 to next scan slot + 1 output register).
- `collision` high at cycle C -> `frozen`=1 from C+1; an UPDATE in progress aborts, so later cars keep old values.
- `rst` mid-sweep: immediate return to reset values, no partial state retained.

## Structure
- Package `car_pkg`: `INIT_X`, `INIT_Y`, `INIT_ORIENT`, `CAR_SPEED` arrays; orientation constants `ORIENT_H`=0, `ORIENT_V`=1; car extents `CAR_LONG`=60, `CAR_SHORT`=30; FSM state enum. `collision_detection` uses the same package.
- One sub-module `car_step`: combinational next-position for one car (speed, orient, wrap/saturate, player mode). Instantiated once and muxed by `upd_idx`.

## Test plan
- Reset -> `carIndex` sequence 0,1,...,7,0 on consecutive cycles; each slot matches INIT tables; `frozen`=0, `busy`=0.
- Car 1 INIT x=630, orient 0, speed 4; one tick -> car 1 x=634; second tick -> x=638; third tick -> x=2 (wrap).
- Car 0 at x=0, `btn_left` held, tick -> x stays 0; `btn_up`+`btn_right` held, y=100 -> y=96, orient 1, x unchanged.
- Tick at T, second tick at T+3 -> exactly one sweep; `busy` high T+1..T+8; all cars advanced once.
- `collision` pulse at T+4 of a sweep -> `frozen`=1 at T+5; cars 0-3 advanced, cars 4-7 unchanged; later ticks no effect; `restart` -> INIT values, `frozen`=0.
- `rst` asserted mid-sweep, asynchronously -> outputs return to reset values immediately, before the next clock edge.
